// File: rtl/operand_entry.sv
// Two-button operand entry: synchronize, debounce and edge-detect each button, then drive a
// 4-state entry FSM holding two 3-bit operands. Outputs are registered, and update pulses the cycle after a change.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [1:0] num_selected,
  output logic [2:0] num_A,
  output logic [2:0] num_B,
  output logic       update
);

  typedef enum logic [1:0] {
    EDIT_A   = 2'd0,
    EDIT_B   = 2'd1,
    SHOW_SUM = 2'd2,
    HOLD     = 2'd3
  } state_t;

  localparam int BTN_NEXT = 0;
  localparam int BTN_INC  = 1;
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       level_q, level_d;
  logic [1:0][15:0] cnt_q, cnt_d;
  logic [1:0]       press;

  state_t     state_q, state_d;
  logic [2:0] num_a_q, num_a_d;
  logic [2:0] num_b_q, num_b_d;
  logic       update_q, update_d;

  always_comb begin
    sync1_d = {btn_inc, btn_next};
    sync2_d = sync1_q;
  end

  // A disagreeing sample advances the count; the level flips on the last one and an agreeing sample clears it.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press   = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          cnt_d[i]   = 16'd0;
          level_d[i] = ~level_q[i];
          press[i]   = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end else begin
        cnt_d[i] = 16'd0;
      end
    end
  end

  // If next and inc are both pressed in the same cycle, next wins and the inc press is dropped.
  always_comb begin
    state_d = state_q;
    num_a_d = num_a_q;
    num_b_d = num_b_q;
    if (press[BTN_NEXT]) begin
      case (state_q)
        EDIT_A:   state_d = EDIT_B;
        EDIT_B:   state_d = SHOW_SUM;
        SHOW_SUM: state_d = HOLD;
        default: begin
          state_d = EDIT_A;
          num_a_d = 3'd0;
          num_b_d = 3'd0;
        end
      endcase
    end else if (press[BTN_INC]) begin
      case (state_q)
        EDIT_A:  num_a_d = num_a_q + 3'd1;
        EDIT_B:  num_b_d = num_b_q + 3'd1;
        default: ;
      endcase
    end
    update_d = (state_d != state_q) || (num_a_d != num_a_q) || (num_b_d != num_b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      level_q  <= 2'b00;
      cnt_q    <= '0;
      state_q  <= EDIT_A;
      num_a_q  <= 3'd0;
      num_b_q  <= 3'd0;
      update_q <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      num_a_q  <= num_a_d;
      num_b_q  <= num_b_d;
      update_q <= update_d;
    end
  end

  assign num_selected = state_q;
  assign num_A        = num_a_q;
  assign num_B        = num_b_q;
  assign update       = update_q;

endmodule

// File: tb/tb_operand_entry.sv
// Bench for operand_entry: vector table, directed multi-cycle corner cases, and random clean
// presses and glitches checked against a simple entry-state model.
module tb_operand_entry;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       btn_next;
  logic       btn_inc;
  logic [1:0] num_selected;
  logic [2:0] num_A;
  logic [2:0] num_B;
  logic       update;

  int checks   = 0;
  int failures = 0;
  int upd_cnt  = 0;

  operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_next     (btn_next),
    .btn_inc      (btn_inc),
    .num_selected (num_selected),
    .num_A        (num_A),
    .num_B        (num_B),
    .update       (update)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (update === 1'b1) upd_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic n;
    logic i;
    int   sel;
    int   a;
    int   b;
    int   upd;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Clean press: high long enough to debounce, then low long enough for the release to settle.
  task automatic press(input logic n, input logic i, input int hi_len, input int lo_len);
    @(posedge clk); #1;
    btn_next = n;
    btn_inc  = i;
    repeat (hi_len) @(posedge clk);
    #1;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    repeat (lo_len) @(posedge clk);
    #1;
  endtask

  // Counts rising edges from now until any of sel/A/B differs; -1 if none within the window.
  task automatic measure(output int k);
    logic [7:0] snap;
    snap = {num_selected, num_A, num_B};
    k = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if ({num_selected, num_A, num_B} != snap) begin
        k = c;
        break;
      end
    end
  endtask

  int m_sel, m_a, m_b;

  task automatic model_apply(input logic n, input logic i);
    if (n) begin
      if (m_sel == 3) begin
        m_a = 0;
        m_b = 0;
      end
      m_sel = (m_sel + 1) % 4;
    end else if (i) begin
      if (m_sel == 0) m_a = (m_a + 1) % 8;
      else if (m_sel == 1) m_b = (m_b + 1) % 8;
    end
  endtask

  initial begin
    int u0, k, op, ps, pa, pb, exp_upd;
    logic n, i;

    for (int j = 0; j < 3; j++) tbl[j] = '{1'b0, 1'b1, 0, j + 1, 0, 1};
    tbl[3] = '{1'b1, 1'b0, 1, 3, 0, 1};
    for (int j = 0; j < 6; j++) tbl[4 + j] = '{1'b0, 1'b1, 1, 3, j + 1, 1};
    tbl[10] = '{1'b1, 1'b0, 2, 3, 6, 1};
    tbl[11] = '{1'b0, 1'b1, 2, 3, 6, 0};
    tbl[12] = '{1'b1, 1'b0, 3, 3, 6, 1};
    tbl[13] = '{1'b0, 1'b1, 3, 3, 6, 0};
    tbl[14] = '{1'b1, 1'b0, 0, 0, 0, 1};
    tbl[15] = '{1'b0, 1'b1, 0, 1, 0, 1};
    tbl[16] = '{1'b0, 1'b1, 0, 2, 0, 1};
    tbl[17] = '{1'b1, 1'b1, 1, 2, 0, 1};
    tbl[18] = '{1'b0, 1'b1, 1, 2, 1, 1};

    rst      = 1'b0;
    btn_next = 1'b0;
    btn_inc  = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("reset_sel", int'(num_selected), 0);
    chk("reset_a",   int'(num_A), 0);
    chk("reset_b",   int'(num_B), 0);
    chk("reset_upd", int'(update), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Vector table: full entry cycle, ignored incs, then simultaneous presses.
    for (int t = 0; t < 19; t++) begin
      u0 = upd_cnt;
      press(tbl[t].n, tbl[t].i, D + 4, D + 6);
      chk($sformatf("tbl%0d_sel", t), int'(num_selected), tbl[t].sel);
      chk($sformatf("tbl%0d_a", t),   int'(num_A), tbl[t].a);
      chk($sformatf("tbl%0d_b", t),   int'(num_B), tbl[t].b);
      chk($sformatf("tbl%0d_upd", t), upd_cnt - u0, tbl[t].upd);
    end

    // Wrap of operand A, with latency measured on every press.
    do_reset();
    u0 = upd_cnt;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      btn_inc = 1'b1;
      measure(k);
      chk_range($sformatf("wrap%0d_latency", j), k, D, D + 4);
      repeat (4) @(posedge clk);
      #1 btn_inc = 1'b0;
      repeat (D + 6) @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_a", j), int'(num_A), (j + 1) % 8);
      chk($sformatf("wrap%0d_b", j), int'(num_B), 0);
    end
    chk("wrap_upd_pulses", upd_cnt - u0, 8);

    // Bounce: toggle every 2 cycles for 20 cycles, then hold high.
    do_reset();
    u0 = upd_cnt;
    @(posedge clk); #1;
    for (int j = 0; j < 10; j++) begin
      btn_inc = ~btn_inc;
      repeat (2) @(posedge clk);
      #1;
    end
    btn_inc = 1'b1;
    measure(k);
    chk_range("bounce_latency", k, D, D + 4);
    repeat (D + 6) @(posedge clk);
    #1 btn_inc = 1'b0;
    repeat (D + 6) @(posedge clk);
    #1;
    chk("bounce_a", int'(num_A), 1);
    chk("bounce_upd", upd_cnt - u0, 1);

    // Reset mid-debounce in EDIT_B with A=5.
    do_reset();
    for (int j = 0; j < 5; j++) press(1'b0, 1'b1, D + 4, D + 6);
    press(1'b1, 1'b0, D + 4, D + 6);
    chk("pre_rst_sel", int'(num_selected), 1);
    chk("pre_rst_a", int'(num_A), 5);
    @(posedge clk); #1;
    btn_inc = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sel", int'(num_selected), 0);
    chk("midrst_a", int'(num_A), 0);
    chk("midrst_b", int'(num_B), 0);
    chk("midrst_upd", int'(update), 0);
    btn_inc = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    u0 = upd_cnt;
    repeat (3 * D + 10) @(posedge clk);
    #1;
    chk("postrst_sel", int'(num_selected), 0);
    chk("postrst_a", int'(num_A), 0);
    chk("postrst_upd", upd_cnt - u0, 0);

    // Button held high across reset release counts as one fresh press.
    #2 rst = 1'b1;
    btn_next = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    u0 = upd_cnt;
    repeat (3 * D + 10) @(posedge clk);
    #1;
    chk("held_sel", int'(num_selected), 1);
    chk("held_upd", upd_cnt - u0, 1);
    btn_next = 1'b0;
    repeat (3 * D + 10) @(posedge clk);
    #1;
    chk("held_release_sel", int'(num_selected), 1);
    chk("held_release_upd", upd_cnt - u0, 1);

    // Glitch one cycle short of the debounce window.
    u0 = upd_cnt;
    @(posedge clk); #1;
    btn_next = 1'b1;
    repeat (D - 1) @(posedge clk);
    #1 btn_next = 1'b0;
    repeat (3 * D + 10) @(posedge clk);
    #1;
    chk("glitch_sel", int'(num_selected), 1);
    chk("glitch_upd", upd_cnt - u0, 0);

    // Random clean presses and short glitches against the model.
    do_reset();
    m_sel = 0;
    m_a   = 0;
    m_b   = 0;
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        u0 = upd_cnt;
        @(posedge clk); #1;
        if ($urandom_range(0, 1) == 0) btn_next = 1'b1;
        else btn_inc = 1'b1;
        repeat ($urandom_range(1, D - 1)) @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_inc  = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;
        chk($sformatf("rnd%0d_glitch_upd", t), upd_cnt - u0, 0);
      end
      op = $urandom_range(0, 9);
      n  = (op <= 3) || (op == 9);
      i  = (op >= 4);
      ps = m_sel;
      pa = m_a;
      pb = m_b;
      model_apply(n, i);
      exp_upd = (ps != m_sel || pa != m_a || pb != m_b) ? 1 : 0;
      u0 = upd_cnt;
      press(n, i, D + 2 + $urandom_range(0, 6), D + 4 + $urandom_range(0, 6));
      chk($sformatf("rnd%0d_sel", t), int'(num_selected), m_sel);
      chk($sformatf("rnd%0d_a", t),   int'(num_A), m_a);
      chk($sformatf("rnd%0d_b", t),   int'(num_B), m_b);
      chk($sformatf("rnd%0d_upd", t), upd_cnt - u0, exp_upd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples for a button level change; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port btn_next  input  1  raw, asynchronous, bouncy button; a press advances the entry state.
REQ-005 SHALL have port btn_inc  input  1  raw, asynchronous, bouncy button; a press increments the operand being edited.
REQ-006 SHALL have port num_selected  output  2  current entry state code, feeds the sum calculator selector.
REQ-007 SHALL have port num_A  output  3  operand A, unsigned.
REQ-008 SHALL have port num_B  output  3  operand B, unsigned.
REQ-009 SHALL have port update  output  1  one-cycle pulse, high in the cycle after any of num_selected/num_A/num_B changed value.

Function
REQ-010 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-011 SHALL keep one debounced level per button; it toggles only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts the count at 0.
REQ-012 SHALL generate a press event as a one-cycle pulse when a debounced level goes 0->1; releases generate no event.
REQ-013 SHALL, for a clean raw rise held stable, change outputs no earlier than DEBOUNCE_CYCLES and no later than DEBOUNCE_CYCLES+4 cycles after the raw edge, exactly once per press.
REQ-014 SHALL ignore raw pulses or bounces shorter than DEBOUNCE_CYCLES cycles: no event, no output change.
REQ-015 SHALL implement a 4-state FSM, num_selected equal to state code: EDIT_A=0, EDIT_B=1, SHOW_SUM=2, HOLD=3.
REQ-016 SHALL advance on each next event: EDIT_A->EDIT_B->SHOW_SUM->HOLD->EDIT_A.
REQ-017 SHALL clear num_A and num_B to 0 on the same edge as the transition HOLD->EDIT_A.
REQ-018 SHALL, on an inc event in EDIT_A, set num_A to (num_A+1) mod 8, i.e. 7 wraps to 0; in EDIT_B likewise for num_B.
REQ-019 SHALL ignore inc events in SHOW_SUM and HOLD; operands hold.
REQ-020 SHALL, when next and inc events occur in the same cycle, act on next only and discard inc.
REQ-021 SHALL treat a button held continuously as one press; no auto-repeat.
REQ-022 SHALL drive all outputs from registers, no combinational path from inputs to outputs.
REQ-023 SHALL pulse update for exactly one cycle per output change; inc in SHOW_SUM/HOLD produces no pulse.

Reset
REQ-024 SHALL on rst assertion immediately force num_selected=0, num_A=0, num_B=0, update=0, synchronizers, debounced levels and counters to 0, without waiting for clk.
REQ-025 SHALL, on rst during a partial debounce count, discard that count; no event from pre-reset activity.
REQ-026 SHALL treat a button held high across rst release as a fresh press, producing exactly one event after debounce.
REQ-027 SHALL begin normal operation on the first rising clk edge after rst deassertion.

Verification
REQ-028 SHALL cover reset: assert rst mid-count with num_A=5 in EDIT_B -> outputs 0/0/0 immediately, no event after release.
REQ-029 SHALL cover wrap: DEBOUNCE_CYCLES=4, eight clean inc presses in EDIT_A -> num_A 1..7 then 0, eight update pulses, num_B stays 0.
REQ-030 SHALL cover bounce: btn_inc toggled every 2 cycles for 20 cycles then held high -> exactly one increment, within DEBOUNCE_CYCLES+4 cycles of final stable edge.
REQ-031 SHALL cover full cycle: A=3, next, B=6, next -> num_selected=2; next -> 3; inc ignored; next -> num_selected=0, num_A=0, num_B=0.
REQ-032 SHALL cover simultaneity: both buttons rise on the same cycle in EDIT_A with num_A=2 -> num_selected=1, num_A stays 2.
REQ-033 SHALL cover short glitch: btn_next high for DEBOUNCE_CYCLES-1 cycles -> no state change, no update pulse.
